// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder.
//
// Contents:
//   qd_state_e  - decoder FSM state (INIT while the input pipeline fills, RUN afterwards)
//   quad_t      - sampled {a,b} pair, a in bit 1
//   step_dec_t  - classification of one {a,b} sample-to-sample transition
//   step_dec()  - classifies prev -> cur as a legal step (with direction), no move, or illegal
//   FILTER_ON   - build-time switch for the input glitch filter, set by macro QUAD_FILTER_EN
package quad_decoder_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qd_state_e;

    typedef logic [1:0] quad_t;

    typedef struct packed {
        logic valid;    // a legal single-bit Gray step occurred
        logic up;       // direction of that step: 1 = forward
        logic illegal;  // both bits changed in one sample
    } step_dec_t;

`ifdef QUAD_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    // Converting the Gray pair to a 2-bit position turns direction into a
    // modulo-4 difference: +1 forward, -1 (3) reverse, 2 means both bits flipped.
    function automatic step_dec_t step_dec(input quad_t prev, input quad_t cur);
        step_dec_t  res;
        logic [1:0] prev_pos;
        logic [1:0] cur_pos;
        logic [1:0] delta;
        prev_pos = {prev[1], prev[1] ^ prev[0]};
        cur_pos  = {cur[1],  cur[1]  ^ cur[0]};
        delta    = cur_pos - prev_pos;
        res      = '{valid: 1'b0, up: 1'b0, illegal: 1'b0};
        case (delta)
            2'd1:    res = '{valid: 1'b1, up: 1'b1, illegal: 1'b0};
            2'd3:    res = '{valid: 1'b1, up: 1'b0, illegal: 1'b0};
            2'd2:    res = '{valid: 1'b0, up: 1'b0, illegal: 1'b1};
            default: res = '{valid: 1'b0, up: 1'b0, illegal: 1'b0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_decoder_sync.sv
// One encoder channel: multi-flop synchronizer followed by an optional
// stability filter (enabled when macro QUAD_FILTER_EN is defined).
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset (all flops to 0)
//   d_i  in   asynchronous encoder pin
//   q_o  out  synchronized (and, if enabled, filtered) level
module quad_decoder_sync
    import quad_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Synchronizer shift chain; the last stage is the first usable sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    if (FILTER_ON) begin : g_filt
        localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

        logic [FCW-1:0] cnt_q;
        logic [FCW-1:0] cnt_d;
        logic           filt_q;
        logic           filt_d;

        // Counts consecutive samples that disagree with the filtered level;
        // the level flips only after FILT_LEN of them in a row.
        always_comb begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
            if (sync_q[SYNC_STAGES-1] == filt_q) begin
                cnt_d = '0;
            end else if (cnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + FCW'(1);
            end
        end

        // Filter state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                filt_q <= filt_d;
                cnt_q  <= cnt_d;
            end
        end

        assign q_o = filt_q;
    end else begin : g_direct
        assign q_o = sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature (Gray-coded) rotary encoder decoder with signed position count.
// Optional glitch filter on both channels: define macro QUAD_FILTER_EN.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   a_in     in   encoder channel A (asynchronous)
//   b_in     in   encoder channel B (asynchronous)
//   en       in   1 = decode and count, 0 = only track the inputs
//   clr      in   synchronous clear of count (wins over a coincident step)
//   err_clr  in   clears the sticky error (loses to a coincident illegal move)
//   count    out  signed position, wraps modulo 2^CNT_W
//   dir      out  direction of the last legal step, 1 = forward
//   step     out  one-cycle pulse per legal step
//   err      out  sticky illegal-transition flag
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_in,
    input  logic                    b_in,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    err_clr,
    output logic signed [CNT_W-1:0] count,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    // INIT covers the whole input pipeline so the first decoded sample is real data.
    localparam int FILT_CYC = FILTER_ON ? FILT_LEN : 0;
    localparam int INIT_LEN = SYNC_STAGES + FILT_CYC + 1;
    localparam int ICW      = $clog2(INIT_LEN);

    logic                    a_sync_s;
    logic                    b_sync_s;
    quad_t                   cur_s;
    step_dec_t               dec_s;
    logic                    init_last_s;
    logic                    err_set_s;
    logic [CNT_W-1:0]        count_nxt_s;

    qd_state_e               state_q;
    qd_state_e               state_d;
    logic [ICW-1:0]          init_cnt_q;
    logic [ICW-1:0]          init_cnt_d;
    quad_t                   prev_q;
    quad_t                   prev_d;
    logic signed [CNT_W-1:0] count_q;
    logic signed [CNT_W-1:0] count_d;
    logic                    dir_q;
    logic                    dir_d;
    logic                    step_q;
    logic                    step_d;
    logic                    err_q;
    logic                    err_d;

    quad_decoder_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_a (
        .clk (clk),
        .rst (rst),
        .d_i (a_in),
        .q_o (a_sync_s)
    );

    quad_decoder_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_b (
        .clk (clk),
        .rst (rst),
        .d_i (b_in),
        .q_o (b_sync_s)
    );

    assign cur_s       = {a_sync_s, b_sync_s};
    assign dec_s       = step_dec(prev_q, cur_s);
    assign init_last_s = (state_q == INIT) && (init_cnt_q == ICW'(INIT_LEN - 1));

    // FSM state and INIT cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // FSM next state: leave INIT after its last cycle, then stay in RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_last_s) begin
                    state_d    = RUN;
                    init_cnt_d = '0;
                end else begin
                    state_d    = INIT;
                    init_cnt_d = init_cnt_q + ICW'(1);
                end
            end
            RUN: begin
                state_d    = RUN;
                init_cnt_d = '0;
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Datapath next values: prev tracking, step decode, count, dir and error flag.
    always_comb begin
        prev_d      = prev_q;
        count_nxt_s = count_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_set_s   = 1'b0;
        case (state_q)
            INIT: begin
                if (init_last_s) begin
                    prev_d = cur_s;
                end else begin
                    prev_d = prev_q;
                end
            end
            RUN: begin
                // prev follows the input even when disabled, so re-enabling never
                // sees a stale transition.
                prev_d = cur_s;
                if (en && dec_s.valid) begin
                    step_d = 1'b1;
                    dir_d  = dec_s.up;
                    if (dec_s.up) begin
                        count_nxt_s = count_q + CNT_W'(1);
                    end else begin
                        count_nxt_s = count_q - CNT_W'(1);
                    end
                end else if (en && dec_s.illegal) begin
                    err_set_s = 1'b1;
                end else begin
                    step_d = 1'b0;
                end
            end
            default: begin
                prev_d = prev_q;
            end
        endcase
        count_d = clr ? '0 : count_nxt_s;
        err_d   = err_set_s ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Datapath registers; all outputs come straight from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 2'b00;
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 4;
`ifdef QUAD_FILTER_EN
    localparam int PIPE = SYNC_STAGES + FILT_LEN;
`else
    localparam int PIPE = SYNC_STAGES;
`endif
    localparam int INIT_LEN = PIPE + 1;

    logic              clk;
    logic              rst;
    logic              a_in;
    logic              b_in;
    logic              en;
    logic              clr;
    logic              err_clr;
    logic [CNT_W-1:0]  count_o;
    logic              dir_o;
    logic              step_o;
    logic              err_o;

    quad_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_in    (a_in),
        .b_in    (b_in),
        .en      (en),
        .clr     (clr),
        .err_clr (err_clr),
        .count   (count_o),
        .dir     (dir_o),
        .step    (step_o),
        .err     (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [CNT_W-1:0] count;
        logic             dir;
        logic             step;
        logic             err;
    } exp_t;

    exp_t sb_q[$];

    int n_checks;
    int n_errors;
    int steps_seen;

    // Reference model state
    logic [1:0]       m_sy [SYNC_STAGES];
    logic [1:0]       m_hist [FILT_LEN];
    logic [1:0]       m_filt;
    logic             m_run;
    int               m_icnt;
    logic [1:0]       m_prev;
    logic [CNT_W-1:0] m_count;
    logic             m_dir;
    logic             m_step;
    logic             m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_fwd(input logic [1:0] p, input logic [1:0] c);
        return (p == 2'b00 && c == 2'b01) || (p == 2'b01 && c == 2'b11) ||
               (p == 2'b11 && c == 2'b10) || (p == 2'b10 && c == 2'b00);
    endfunction

    // Model of one rising edge with the inputs currently driven.
    task automatic model_edge();
        logic [1:0] cur;
        logic       set_err;
        logic       all_eq;
        exp_t       e;
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_sy[i] = 2'b00;
            for (int i = 0; i < FILT_LEN; i++) m_hist[i] = 2'b00;
            m_filt  = 2'b00;
            m_run   = 1'b0;
            m_icnt  = 0;
            m_prev  = 2'b00;
            m_count = '0;
            m_dir   = 1'b0;
            m_step  = 1'b0;
            m_err   = 1'b0;
        end else begin
`ifdef QUAD_FILTER_EN
            cur = m_filt;
`else
            cur = m_sy[SYNC_STAGES-1];
`endif
            m_step  = 1'b0;
            set_err = 1'b0;
            if (!m_run) begin
                if (m_icnt == INIT_LEN - 1) begin
                    m_prev = cur;
                    m_run  = 1'b1;
                end else begin
                    m_icnt++;
                end
            end else begin
                if (en && is_fwd(m_prev, cur)) begin
                    m_count = m_count + 16'd1;
                    m_dir   = 1'b1;
                    m_step  = 1'b1;
                end else if (en && is_fwd(cur, m_prev)) begin
                    m_count = m_count - 16'd1;
                    m_dir   = 1'b0;
                    m_step  = 1'b1;
                end
                set_err = en && ((m_prev ^ cur) == 2'b11);
                m_prev  = cur;
            end
            if (clr) m_count = '0;
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
`ifdef QUAD_FILTER_EN
            for (int i = FILT_LEN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = m_sy[SYNC_STAGES-1];
            for (int j = 0; j < 2; j++) begin
                all_eq = 1'b1;
                for (int k = 1; k < FILT_LEN; k++)
                    if (m_hist[k][j] != m_hist[0][j]) all_eq = 1'b0;
                if (all_eq) m_filt[j] = m_hist[0][j];
            end
`else
            all_eq = 1'b0;
`endif
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_sy[i] = m_sy[i-1];
            m_sy[0] = {a_in, b_in};
        end
        e.count = m_count;
        e.dir   = m_dir;
        e.step  = m_step;
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, predict, then compare on the falling edge.
    task automatic cyc(input logic [1:0] ab, input logic clr_v, input logic ec_v);
        exp_t e;
        a_in    = ab[1];
        b_in    = ab[0];
        clr     = clr_v;
        err_clr = ec_v;
        model_edge();
        @(negedge clk);
        e = sb_q.pop_front();
        check_val("sb_count", 32'(count_o), 32'(e.count));
        check_val("sb_dir",   32'(dir_o),   32'(e.dir));
        check_val("sb_step",  32'(step_o),  32'(e.step));
        check_val("sb_err",   32'(err_o),   32'(e.err));
        if (step_o === 1'b1) steps_seen++;
    endtask

    // Hold a value for n cycles; report the cycle index of the first step pulse.
    task automatic seg(input logic [1:0] ab, input int n, output int first);
        first = 0;
        for (int i = 1; i <= n; i++) begin
            cyc(ab, 1'b0, 1'b0);
            if (step_o === 1'b1 && first == 0) first = i;
        end
    endtask

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    initial begin
        int first;
        int pos;
        logic [1:0] fwd_seq [4];
        n_checks   = 0;
        n_errors   = 0;
        steps_seen = 0;
        rst = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0; a_in = 1'b1; b_in = 1'b1;

        // Reset state
        cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b0, 1'b0);
        check_val("rst_count", 32'(count_o), 32'h0);
        check_val("rst_step",  32'(step_o),  32'h0);
        check_val("rst_err",   32'(err_o),   32'h0);
        check_val("rst_dir",   32'(dir_o),   32'h0);

        // INIT with inputs at 11: nothing happens
        rst = 1'b0;
        steps_seen = 0;
        seg(2'b11, 12, first);
        check_val("init_steps", 32'(steps_seen), 32'd0);
        check_val("init_count", 32'(count_o), 32'h0);
        check_val("init_err",   32'(err_o),   32'h0);

        // Move to 00 legally, clear
        seg(2'b10, 10, first);
        seg(2'b00, 10, first);
        check_val("pre_count", 32'(count_o), 32'd2);
        cyc(2'b00, 1'b1, 1'b0);
        seg(2'b00, 4, first);
        check_val("clr_count", 32'(count_o), 32'h0);

        // Forward cycle with latency
        fwd_seq[0] = 2'b01; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b10; fwd_seq[3] = 2'b00;
        steps_seen = 0;
        for (int i = 0; i < 4; i++) begin
            seg(fwd_seq[i], 10, first);
            check_val("fwd_latency", 32'(first), 32'(PIPE + 1));
        end
        check_val("fwd_steps", 32'(steps_seen), 32'd4);
        check_val("fwd_count", 32'(count_o), 32'd4);
        check_val("fwd_dir",   32'(dir_o),   32'd1);

        // Reverse from zero
        cyc(2'b00, 1'b1, 1'b0);
        seg(2'b00, 4, first);
        seg(2'b10, 10, first);
        check_val("rev_wrap", 32'(count_o), 32'hFFFF);
        seg(2'b11, 10, first);
        seg(2'b01, 10, first);
        seg(2'b00, 10, first);
        seg(2'b10, 10, first);
        check_val("rev_count", 32'(count_o), 32'hFFFB);
        check_val("rev_dir",   32'(dir_o),   32'd0);

`ifndef QUAD_FILTER_EN
        // Positive overflow: 32767 single-cycle steps then one more
        cyc(2'b10, 1'b1, 1'b0);
        seg(2'b10, 4, first);
        pos = 3;
        for (int i = 0; i < 32767; i++) begin
            pos = pos + 1;
            cyc(ab_of(pos), 1'b0, 1'b0);
        end
        seg(ab_of(pos), PIPE + 2, first);
        check_val("max_count", 32'(count_o), 32'h7FFF);
        pos = pos + 1;
        seg(ab_of(pos), 10, first);
        check_val("ovf_count", 32'(count_o), 32'h8000);
        check_val("ovf_dir",   32'(dir_o),   32'd1);
`endif

        // Illegal jump and err handling (now at 10)
        seg(2'b00, 10, first);
        cyc(2'b00, 1'b1, 1'b0);
        seg(2'b00, 4, first);
        steps_seen = 0;
        seg(2'b11, 10, first);
        check_val("ill_err",   32'(err_o),   32'd1);
        check_val("ill_count", 32'(count_o), 32'h0);
        check_val("ill_steps", 32'(steps_seen), 32'd0);
        cyc(2'b11, 1'b0, 1'b1);
        seg(2'b11, 4, first);
        check_val("errclr_err", 32'(err_o), 32'd0);
        cyc(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < PIPE - 1; i++) cyc(2'b00, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1);
        seg(2'b00, 4, first);
        check_val("set_wins_err", 32'(err_o), 32'd1);
        cyc(2'b00, 1'b0, 1'b1);
        seg(2'b00, 4, first);
        check_val("err_cleared", 32'(err_o), 32'd0);

        // clr coincident with a forward step
        seg(2'b01, 10, first);
        check_val("pre_clr_count", 32'(count_o), 32'd1);
        cyc(2'b11, 1'b0, 1'b0);
        for (int i = 0; i < PIPE - 1; i++) cyc(2'b11, 1'b0, 1'b0);
        cyc(2'b11, 1'b1, 1'b0);
        check_val("clrstep_step",  32'(step_o),  32'd1);
        check_val("clrstep_count", 32'(count_o), 32'h0);
        check_val("clrstep_dir",   32'(dir_o),   32'd1);
        seg(2'b11, 4, first);

        // en=0 during three steps
        en = 1'b0;
        steps_seen = 0;
        seg(2'b10, 10, first);
        seg(2'b00, 10, first);
        seg(2'b01, 10, first);
        en = 1'b1;
        seg(2'b01, 4, first);
        check_val("dis_count", 32'(count_o), 32'h0);
        check_val("dis_steps", 32'(steps_seen), 32'd0);
        seg(2'b11, 10, first);
        check_val("reen_count", 32'(count_o), 32'd1);

`ifdef QUAD_FILTER_EN
        // Two-cycle glitch on a is swallowed by the filter
        steps_seen = 0;
        cyc(2'b01, 1'b0, 1'b0);
        cyc(2'b01, 1'b0, 1'b0);
        seg(2'b11, PIPE + 6, first);
        check_val("glitch_steps", 32'(steps_seen), 32'd0);
        check_val("glitch_err",   32'(err_o),      32'd0);
`endif

        // Reset mid-operation
        seg(2'b10, 10, first);
        check_val("mid_count", 32'(count_o), 32'd2);
        rst = 1'b1;
        cyc(2'b10, 1'b0, 1'b0);
        rst = 1'b0;
        check_val("mid_rst_count", 32'(count_o), 32'h0);
        steps_seen = 0;
        seg(2'b10, PIPE + 6, first);
        check_val("mid_rst_steps", 32'(steps_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
